// File: rtl/capture_sequencer_pkg.sv
// Shared types and constants for the ADC capture sequencer.
package capture_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DRAIN
   } state_t;

   localparam int unsigned SAMPLE_W_DEF = 12;
   localparam int unsigned DEPTH_DEF    = 10;
   localparam int unsigned PTR_W        = 4;

   // Buffer pointer increment, wrapping at depth-1 back to 0.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                                input int unsigned      depth);
      return (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
   endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// Sample-in / transmit-out handshake bundle of the capture sequencer.
// master = the sequencer, slave = ADC reader plus Arduino writer side.
interface capture_sequencer_if
   import capture_pkg::*;
#(
   parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
) ();

   logic                sample_valid;
   logic [SAMPLE_W-1:0] sample;
   logic                adc_en;
   logic [SAMPLE_W-1:0] tx_data;
   logic                tx_valid;
   logic                tx_ready;

   modport master (
      input  sample_valid, sample, tx_ready,
      output adc_en, tx_data, tx_valid
   );

   modport slave (
      output sample_valid, sample, tx_ready,
      input  adc_en, tx_data, tx_valid
   );

endinterface

// File: rtl/capture_sequencer_sample_buffer.sv
// Register-array FIFO holding one acquisition. Contents survive reset and
// clear; only pointers and level are cleared. head is registered and always
// shows the entry at the read pointer.
module sample_buffer
   import capture_pkg::*;
#(
   parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                wr_en,
   input  logic [SAMPLE_W-1:0] wr_data,
   input  logic                rd_adv,
   output logic [SAMPLE_W-1:0] head,
   output logic [PTR_W-1:0]    level
);

   logic [SAMPLE_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_next;
   logic [SAMPLE_W-1:0] head_d;
   logic                wr_go;

   assign wr_go = wr_en && !clear;

   // Sample storage, written at the write pointer; deliberately not reset.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (wr_go && wr_ptr == PTR_W'(i)) mem[i] <= wr_data;
      end
   end

   // Pointers and fill level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_inc(wr_ptr, DEPTH);
         rd_ptr <= rd_next;
         case ({wr_en, rd_adv})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Next head: entry at the upcoming read pointer, bypassing a same-cycle
   // write so a sample is visible the cycle after it arrives.
   always_comb begin
      rd_next = clear ? '0 : (rd_adv ? ptr_inc(rd_ptr, DEPTH) : rd_ptr);
      head_d  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (rd_next == PTR_W'(i)) head_d = mem[i];
      end
      if (wr_go && wr_ptr == rd_next) head_d = wr_data;
   end

   // Registered head output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) head <= '0;
      else     head <= head_d;
   end

endmodule

// File: rtl/capture_sequencer.sv
// Acquisition sequencer: enables the ADC reader, buffers DEPTH samples, then
// drains them oldest-first to the Arduino writer over valid/ready.
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   capture_sequencer_if.master bus,
   output logic                busy,
   output logic                done,
   output logic [PTR_W-1:0]    level
);

   state_t              state_q, state_d;
   logic                buf_clear, buf_wr, xfer, last_wr, last_xfer;
   logic                adc_en_q, tx_valid_q;
   logic                adc_en_d, tx_valid_d, busy_d, done_d;
   logic [SAMPLE_W-1:0] head;

   assign buf_clear = abort || (state_q == IDLE && start);
   assign buf_wr    = (state_q == CAPTURE) && bus.sample_valid && !abort &&
                      (level < PTR_W'(DEPTH));
   assign xfer      = (state_q == DRAIN) && tx_valid_q && bus.tx_ready && !abort;
   assign last_wr   = buf_wr && (level == PTR_W'(DEPTH - 1));
   assign last_xfer = xfer && (level == PTR_W'(1));

   sample_buffer #(
      .SAMPLE_W (SAMPLE_W),
      .DEPTH    (DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .clear   (buf_clear),
      .wr_en   (buf_wr),
      .wr_data (bus.sample),
      .rd_adv  (xfer),
      .head    (head),
      .level   (level)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; abort overrides everything.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start)     state_d = CAPTURE;
            CAPTURE: if (last_wr)   state_d = DRAIN;
            DRAIN:   if (last_xfer) state_d = IDLE;
            default:                state_d = IDLE;
         endcase
      end
   end

   // Output decode from the upcoming state so outputs register in step with it.
   always_comb begin
      adc_en_d   = (state_d == CAPTURE);
      tx_valid_d = (state_d == DRAIN);
      busy_d     = (state_d != IDLE);
      done_d     = last_xfer;
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adc_en_q   <= 1'b0;
         tx_valid_q <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         adc_en_q   <= adc_en_d;
         tx_valid_q <= tx_valid_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   assign bus.adc_en   = adc_en_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = head;

endmodule
